vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between two requesters.
- The display line-fetch path has fixed priority and issues burst reads that fill the scanline buffer ahead of the pixel output.
- The host path issues single-word reads and writes.
- A starvation guard inserts host slots into long display bursts, and a tag pipeline routes read data back to its owner.

Parameters:
- ADDR_W, 17, VRAM word address width
- DATA_W, 16, VRAM data width
- MEM_LATENCY, 2, cycles from mem_en (read) to valid mem_rdata; minimum 1
- HOST_MAX_WAIT, 8, maximum consecutive cycles a pending host request may be blocked by a burst; minimum 1

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- disp_req  in  1  display burst request; level, held until disp_ack
- disp_addr  in  ADDR_W  burst start address
- disp_len  in  8  burst length minus 1 (1..256 words)
- disp_ack  out  1  one-cycle pulse when the burst is latched
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid
- disp_done  out  1  pulse together with the last disp_rvalid of a burst
- host_req  in  1  host access request; level, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle pulse in the cycle the host access is issued to memory
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after a read
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Burst counters, wait counter and tag pipeline cleared.
  - Reset mid-burst or mid-read drops everything: no rvalid and no done pulses after reset, even for reads already issued to memory.
- Registered outputs:
  - mem_*, disp_ack, host_ack and busy are registered.
  - A grant decided in cycle N drives mem_* in cycle N+1.
- States: IDLE, DISP, HOST.
- IDLE:
  - If disp_req: latch addr/len, pulse disp_ack, go to DISP. This takes priority when both requests are high.
  - Else if host_req: go to HOST.
- HOST:
  - Drive one cycle of mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - Pulse host_ack in the same cycle.
  - Return to IDLE. A host request held high afterwards is treated as a new request.
- DISP:
  - Each cycle issue mem_en=1, mem_we=0 at the burst address.
  - Address increments modulo 2^ADDR_W; remaining-count decrements.
  - After the word with count 0 is issued, go to IDLE.
  - Exactly disp_len+1 reads per burst.
- Starvation guard:
  - Wait counter increments on each cycle with host_req=1, state DISP and no host slot.
  - When the counter reaches HOST_MAX_WAIT, the next cycle is a host slot: the host access is issued with host_ack, and the burst pauses for one cycle. Address and count are held.
  - The counter clears on any host_ack, and whenever host_req=0.
  - If the guard fires exactly on the last burst word, the last word issues first and the host is served from IDLE next. Display priority in IDLE does not override a saturated wait counter: a saturated counter forces HOST.
- disp_req in IDLE immediately after a burst is granted again, with no gap required.
- Tag pipeline:
  - Depth MEM_LATENCY. On each mem_en with mem_we=0, push {valid, owner, last}; otherwise push an empty tag.
  - At the output: owner=display gives disp_rvalid=1 and disp_rdata=mem_rdata; disp_done=1 if last.
  - Owner=host gives host_rvalid=1 and host_rdata=mem_rdata.
  - Host writes produce no rvalid.
- Ordering: read data returns in issue order; display and host returns never collide, because at most one access issues per cycle.
- Throughput: a burst with no host contention sustains one word per cycle.

Test Plan:
- Burst: reset, disp_req with addr=0x00100 and len=3 -> disp_ack 1 cycle later. mem_addr runs 0x100..0x103 on 4 consecutive cycles. disp_rvalid appears on 4 cycles starting MEM_LATENCY after the first mem_en. disp_done comes with the 4th rvalid. busy falls afterwards.
- Host write then read: host_req, we=1, addr=0x55, wdata=0xBEEF -> mem_en/we with host_ack 1 cycle later, no host_rvalid. A read of 0x55 -> host_rvalid with 0xBEEF after MEM_LATENCY (memory model).
- Simultaneous requests: disp_req and host_req asserted in the same IDLE cycle -> display burst is granted first. With len=1, host_ack follows in the cycle after the last display issue.
- Starvation: len=255 burst, host_req asserted 2 cycles into the burst -> host_ack exactly HOST_MAX_WAIT blocked cycles later. The burst pauses 1 cycle, resumes at the correct address, and still issues 256 reads. Read tags route correctly.
- Wrap: disp_addr=2^ADDR_W-2, len=3 -> mem_addr sequence 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset mid-burst: assert reset 5 cycles into a len=15 burst -> the following cycle has mem_en=0, busy=0 and no disp_rvalid/disp_done. A new request after reset is serviced normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between display burst reads and host accesses.
// Display has priority; a wait counter forces host slots into long bursts.
module vram_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 16,
  parameter int MEM_LATENCY   = 2,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic [7:0]        disp_len,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic              disp_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(HOST_MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;

  state_t            state;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_cnt;
  logic              b_act;
  logic [WW-1:0]     wait_cnt;
  logic              mem_host;
  logic              mem_last;

  logic [MEM_LATENCY-1:0] tag_v;
  logic [MEM_LATENCY-1:0] tag_h;
  logic [MEM_LATENCY-1:0] tag_l;

  logic guard;
  logic arb;
  logic take_host;
  logic take_burst;
  logic take_disp;

  // b_act: burst words still to issue; b_cnt is the count of the next word
  always_comb begin
    guard      = (state == DISP) && host_req && (wait_cnt == WAIT_LAST);
    arb        = !b_act && (state != HOST);
    take_burst = b_act && !guard;
    take_host  = (b_act && guard) ||
                 (arb && (guard || (!disp_req && host_req)));
    take_disp  = arb && !guard && disp_req;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      b_addr    <= '0;
      b_cnt     <= '0;
      b_act     <= 1'b0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_host  <= 1'b0;
      mem_last  <= 1'b0;
      disp_ack  <= 1'b0;
      host_ack  <= 1'b0;
      tag_v     <= '0;
      tag_h     <= '0;
      tag_l     <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_host <= 1'b0;
      mem_last <= 1'b0;
      disp_ack <= 1'b0;
      host_ack <= 1'b0;

      tag_v[0] <= mem_en && !mem_we;
      tag_h[0] <= mem_host;
      tag_l[0] <= mem_last;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_h[i] <= tag_h[i-1];
        tag_l[i] <= tag_l[i-1];
      end

      if (take_host || !host_req)
        wait_cnt <= '0;
      else if (state == DISP)
        wait_cnt <= wait_cnt + WW'(1);

      if (take_host) begin
        mem_en    <= 1'b1;
        mem_we    <= host_we;
        mem_addr  <= host_addr;
        mem_wdata <= host_wdata;
        mem_host  <= 1'b1;
        host_ack  <= 1'b1;
        state     <= HOST;
      end else if (take_burst) begin
        mem_en   <= 1'b1;
        mem_addr <= b_addr;
        mem_last <= (b_cnt == 8'd0);
        b_addr   <= b_addr + ADDR_W'(1);
        b_cnt    <= b_cnt - 8'd1;
        b_act    <= (b_cnt != 8'd0);
        state    <= DISP;
      end else if (take_disp) begin
        disp_ack <= 1'b1;
        mem_en   <= 1'b1;
        mem_addr <= disp_addr;
        mem_last <= (disp_len == 8'd0);
        b_addr   <= disp_addr + ADDR_W'(1);
        b_cnt    <= disp_len - 8'd1;
        b_act    <= (disp_len != 8'd0);
        state    <= DISP;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign disp_rvalid = tag_v[MEM_LATENCY-1] && !tag_h[MEM_LATENCY-1];
  assign host_rvalid = tag_v[MEM_LATENCY-1] && tag_h[MEM_LATENCY-1];
  assign disp_done   = disp_rvalid && tag_l[MEM_LATENCY-1];
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign busy        = (state != IDLE);

endmodule
